// File: rtl/r2l_exp.sv
// ---------------------------------------------------------------------------
// r2l_exp -- right-to-left (LSB-first) binary exponentiator
//
// Computes C = A^B mod 2^RES_W by scanning the exponent from its LSB upward.
// Each RUN cycle squares the running base and, when the current exponent bit
// is set, folds that base into the running result. The scan stops as soon as
// the remaining exponent is zero, so latency follows the position of B's MSB
// rather than the full exponent width.
//
// This unit can be swapped for the left-to-right exponentiator because both
// use the same start/Done handshake.
//
// Optional feature macro: R2L_OVF_FLAG_EN
//   When defined, adds the Ovf output. Ovf is a sticky flag meaning the true
//   A^B does not fit in RES_W bits. When undefined, there is no Ovf port and
//   no overflow logic. C behaves the same in both builds.
//
// Ports
//   clk    in   1       clock, rising edge
//   rst    in   1       asynchronous reset, active-high
//   start  in   1       request; only sampled while idle or done
//   A      in   DATA_W  base, captured on the accepting edge
//   B      in   DATA_W  exponent, captured on the accepting edge
//   C      out  RES_W   result, valid while Done=1
//   Done   out  1       level; high from completion until the next accept
//   Ovf    out  1       overflow flag (only with R2L_OVF_FLAG_EN)
// ---------------------------------------------------------------------------
module r2l_exp #(
   parameter int DATA_W = 16,
   parameter int RES_W  = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [DATA_W-1:0] A,
   input  logic [DATA_W-1:0] B,
   output logic [RES_W-1:0]  C,
   output logic              Done
`ifdef R2L_OVF_FLAG_EN
   ,
   output logic              Ovf
`endif
);

   // Product width when the full (untruncated) product is needed for the
   // overflow check.
   localparam int PROD_W = 2 * RES_W;

   // FINISH is a one-cycle stage between "exponent exhausted" and DONE.
   // It publishes the result one edge after the scan ends, which gives the
   // fixed latency of (MSB position + 1) + 2 edges. Like RUN, it ignores
   // start.
   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      RUN    = 2'd1,
      FINISH = 2'd2,
      DONE   = 2'd3
   } state_t;

   state_t              state;
   state_t              state_next;

   logic [RES_W-1:0]    res;
   logic [RES_W-1:0]    res_next;
   logic [RES_W-1:0]    base;
   logic [RES_W-1:0]    base_next;
   logic [DATA_W-1:0]   e;
   logic [DATA_W-1:0]   e_next;
   logic [RES_W-1:0]    c_next;
   logic                done_next;

   logic [RES_W-1:0]    res_mul;
   logic [RES_W-1:0]    base_sq;
   logic [DATA_W-1:0]   e_shr;

   // The exponent shifted right is both the next exponent and the
   // "is there still work after this step" test used by the overflow rule.
   assign e_shr = e >> 1;

`ifdef R2L_OVF_FLAG_EN
   logic [PROD_W-1:0]   res_prod_full;
   logic [PROD_W-1:0]   base_prod_full;
   logic                res_mul_ovf;
   logic                base_sq_ovf;
   logic                ovf_q;
   logic                ovf_next;

   // In the flag build the full double-width products are formed. The low
   // half feeds the datapath. Any set bit in the high half means this
   // product has exceeded 2^RES_W-1.
   assign res_prod_full  = PROD_W'(res) * PROD_W'(base);
   assign base_prod_full = PROD_W'(base) * PROD_W'(base);
   assign res_mul        = res_prod_full[RES_W-1:0];
   assign base_sq        = base_prod_full[RES_W-1:0];
   assign res_mul_ovf    = |res_prod_full[PROD_W-1:RES_W];
   assign base_sq_ovf    = |base_prod_full[PROD_W-1:RES_W];
   assign Ovf            = ovf_q;
`else
   // Without the flag, only the low RES_W bits of each product are kept.
   // This is all the modular result needs.
   assign res_mul = res * base;
   assign base_sq = base * base;
`endif

   // State and datapath registers. An asynchronous reset clears everything,
   // so a reset in the middle of an operation aborts it with no trailing
   // Done.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
         res   <= '0;
         base  <= '0;
         e     <= '0;
         C     <= '0;
         Done  <= 1'b0;
`ifdef R2L_OVF_FLAG_EN
         ovf_q <= 1'b0;
`endif
      end else begin
         state <= state_next;
         res   <= res_next;
         base  <= base_next;
         e     <= e_next;
         C     <= c_next;
         Done  <= done_next;
`ifdef R2L_OVF_FLAG_EN
         ovf_q <= ovf_next;
`endif
      end
   end

   // Next-state and datapath update. Every register holds its value by
   // default. A new request is only honoured from IDLE or DONE, so a start
   // pulse during an operation, or operand changes after capture, have no
   // effect.
   always_comb begin
      state_next = state;
      res_next   = res;
      base_next  = base;
      e_next     = e;
      c_next     = C;
      done_next  = Done;
`ifdef R2L_OVF_FLAG_EN
      ovf_next   = ovf_q;
`endif

      unique case (state)
         IDLE, DONE: begin
            // Accept: load the operands and drop Done on the same edge.
            // In DONE this lets a held start begin the next operation
            // immediately.
            if (start) begin
               res_next   = RES_W'(1);
               base_next  = RES_W'(A);
               e_next     = B;
               done_next  = 1'b0;
`ifdef R2L_OVF_FLAG_EN
               ovf_next   = 1'b0;
`endif
               state_next = RUN;
            end
         end

         RUN: begin
            // One exponent bit is consumed per cycle. The base is always
            // squared. The result picks up the base only for set bits.
            if (e == '0) begin
               state_next = FINISH;
            end else begin
               if (e[0]) begin
                  res_next = res_mul;
               end
               base_next = base_sq;
               e_next    = e_shr;
`ifdef R2L_OVF_FLAG_EN
               // A wrapped square matters only if another set bit remains
               // to multiply it in. The top bit of the exponent is always
               // set, so a non-zero remainder guarantees that.
               if ((e[0] && res_mul_ovf) || (base_sq_ovf && (e_shr != '0))) begin
                  ovf_next = 1'b1;
               end
`endif
            end
         end

         FINISH: begin
            c_next     = res;
            done_next  = 1'b1;
            state_next = DONE;
         end

         default: begin
            state_next = IDLE;
         end
      endcase
   end

endmodule
